// File: rtl/rx_cmd_decoder_if.sv
// Command-decoder bus: received UART words in, register-file and ALU controls out.
// The decoder takes the slave modport; the byte source and sinks take master.
interface rx_cmd_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] rx_data_in;
  logic                  rx_valid_in;
  logic                  reg_wr_en_out;
  logic                  reg_rd_en_out;
  logic [ADDR_WIDTH-1:0] reg_addr_out;
  logic [DATA_WIDTH-1:0] reg_wr_data_out;
  logic [DATA_WIDTH-1:0] alu_a_out;
  logic [DATA_WIDTH-1:0] alu_b_out;
  logic [3:0]            alu_func_out;
  logic                  alu_en_out;
  logic                  cmd_err_out;
  logic                  timeout_err_out;
  logic                  busy_out;

  modport master (
    output rx_data_in, rx_valid_in,
    input  reg_wr_en_out, reg_rd_en_out, reg_addr_out, reg_wr_data_out,
           alu_a_out, alu_b_out, alu_func_out, alu_en_out,
           cmd_err_out, timeout_err_out, busy_out
  );

  modport slave (
    input  rx_data_in, rx_valid_in,
    output reg_wr_en_out, reg_rd_en_out, reg_addr_out, reg_wr_data_out,
           alu_a_out, alu_b_out, alu_func_out, alu_en_out,
           cmd_err_out, timeout_err_out, busy_out
  );
endinterface

// File: rtl/rx_cmd_decoder.sv
// Decodes UART byte frames (write / read / ALU) into register-file and ALU strobes.
// Strobes and error pulses appear one clock after the accepting byte; no backpressure on rx.
module rx_cmd_decoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              reset_n,
  rx_cmd_decoder_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);
  localparam logic [15:0]           CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC
  } state_e;

  state_e                state_q;
  logic [15:0]           cnt_q;
  logic [ADDR_WIDTH-1:0] stg_addr_q;
  logic [DATA_WIDTH-1:0] stg_a_q;
  logic [DATA_WIDTH-1:0] stg_b_q;
  logic                  use_ab_q;

  assign bus.busy_out = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      stg_addr_q          <= '0;
      stg_a_q             <= '0;
      stg_b_q             <= '0;
      use_ab_q            <= 1'b0;
      bus.reg_wr_en_out   <= 1'b0;
      bus.reg_rd_en_out   <= 1'b0;
      bus.reg_addr_out    <= '0;
      bus.reg_wr_data_out <= '0;
      bus.alu_a_out       <= '0;
      bus.alu_b_out       <= '0;
      bus.alu_func_out    <= '0;
      bus.alu_en_out      <= 1'b0;
      bus.cmd_err_out     <= 1'b0;
      bus.timeout_err_out <= 1'b0;
    end else begin
      bus.reg_wr_en_out   <= 1'b0;
      bus.reg_rd_en_out   <= 1'b0;
      bus.alu_en_out      <= 1'b0;
      bus.cmd_err_out     <= 1'b0;
      bus.timeout_err_out <= 1'b0;

      if (bus.rx_valid_in) begin
        cnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (bus.rx_data_in == OP_WR) begin
              state_q <= WR_ADDR;
            end else if (bus.rx_data_in == OP_RD) begin
              state_q <= RD_ADDR;
            end else if (bus.rx_data_in == OP_ALU) begin
              state_q  <= ALU_A;
              use_ab_q <= 1'b1;
            end else if (bus.rx_data_in == OP_ALU_NO) begin
              state_q  <= ALU_FUNC;
              use_ab_q <= 1'b0;
            end else begin
              bus.cmd_err_out <= 1'b1;
            end
          end
          WR_ADDR: begin
            stg_addr_q <= bus.rx_data_in[ADDR_WIDTH-1:0];
            state_q    <= WR_DATA;
          end
          WR_DATA: begin
            bus.reg_addr_out    <= stg_addr_q;
            bus.reg_wr_data_out <= bus.rx_data_in;
            bus.reg_wr_en_out   <= 1'b1;
            state_q             <= IDLE;
          end
          RD_ADDR: begin
            bus.reg_addr_out  <= bus.rx_data_in[ADDR_WIDTH-1:0];
            bus.reg_rd_en_out <= 1'b1;
            state_q           <= IDLE;
          end
          ALU_A: begin
            stg_a_q <= bus.rx_data_in;
            state_q <= ALU_B;
          end
          ALU_B: begin
            stg_b_q <= bus.rx_data_in;
            state_q <= ALU_FUNC;
          end
          ALU_FUNC: begin
            // The no-operand opcode keeps the previously committed A/B.
            if (use_ab_q) begin
              bus.alu_a_out <= stg_a_q;
              bus.alu_b_out <= stg_b_q;
            end
            bus.alu_func_out <= bus.rx_data_in[3:0];
            bus.alu_en_out   <= 1'b1;
            state_q          <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (cnt_q == CNT_LAST) begin
          state_q             <= IDLE;
          cnt_q               <= '0;
          bus.timeout_err_out <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Random and directed frames against a frame-level reference model of the decoder.
module tb_rx_cmd_decoder;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rx_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  rx_cmd_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a frame is a queue of bytes, completed by opcode-specific length.
  logic [7:0] frame[$];
  int         gap;
  logic       e_wr, e_rd, e_alu, e_cerr, e_terr;
  logic [3:0] e_addr, e_func;
  logic [7:0] e_wdat, e_a, e_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
  endtask

  function automatic int frame_len(input logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hCC:   return 4;
      default: return 2;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit v, input logic [7:0] d);
    logic [7:0] b1, b2, b3;
    e_wr = 0; e_rd = 0; e_alu = 0; e_cerr = 0; e_terr = 0;
    if (rst) begin
      frame.delete(); gap = 0;
      e_addr = 0; e_func = 0; e_wdat = 0; e_a = 0; e_b = 0;
      return;
    end
    if (v) begin
      gap = 0;
      if (frame.size() == 0) begin
        if (d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD) frame.push_back(d);
        else e_cerr = 1;
      end else begin
        frame.push_back(d);
        if (frame.size() == frame_len(frame[0])) begin
          b1 = frame[1];
          b2 = (frame.size() > 2) ? frame[2] : 8'h00;
          b3 = (frame.size() > 3) ? frame[3] : 8'h00;
          case (frame[0])
            8'hAA: begin e_wr = 1; e_addr = b1[3:0]; e_wdat = b2; end
            8'hBB: begin e_rd = 1; e_addr = b1[3:0]; end
            8'hCC: begin e_alu = 1; e_a = b1; e_b = b2; e_func = b3[3:0]; end
            default: begin e_alu = 1; e_func = b1[3:0]; end
          endcase
          frame.delete();
        end
      end
    end else if (frame.size() != 0) begin
      gap++;
      if (gap == T) begin
        frame.delete(); gap = 0; e_terr = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("wr_en",   32'(bus.reg_wr_en_out),   32'(e_wr));
    check("rd_en",   32'(bus.reg_rd_en_out),   32'(e_rd));
    check("alu_en",  32'(bus.alu_en_out),      32'(e_alu));
    check("cmd_err", 32'(bus.cmd_err_out),     32'(e_cerr));
    check("tmo_err", 32'(bus.timeout_err_out), 32'(e_terr));
    check("busy",    32'(bus.busy_out),        32'(frame.size() != 0));
    check("addr",    32'(bus.reg_addr_out),    32'(e_addr));
    check("wdat",    32'(bus.reg_wr_data_out), 32'(e_wdat));
    check("alu_a",   32'(bus.alu_a_out),       32'(e_a));
    check("alu_b",   32'(bus.alu_b_out),       32'(e_b));
    check("func",    32'(bus.alu_func_out),    32'(e_func));
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [7:0] d);
    reset_n         = !rst;
    bus.rx_valid_in = v;
    bus.rx_data_in  = d;
    @(posedge clk);
    model_step(rst, v, d);
    #1;
    compare_all();
    reset_n         = 1'b1;
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cycle(0, 1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
  endtask

  logic [7:0] opc[4];
  bit         seen_tmo;

  initial begin
    opc[0] = 8'hAA; opc[1] = 8'hBB; opc[2] = 8'hCC; opc[3] = 8'hDD;
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in  = 8'h00;
    cycle(1, 0, 8'h00);
    cycle(1, 0, 8'h00);
    check("reset_busy", 32'(bus.busy_out), 32'd0);
    check("reset_addr", 32'(bus.reg_addr_out), 32'd0);

    // Write frame
    send(8'hAA); send(8'h05); send(8'h3C);
    check("wr_strobe", 32'(bus.reg_wr_en_out), 32'd1);
    check("wr_addr5",  32'(bus.reg_addr_out), 32'h5);
    check("wr_data",   32'(bus.reg_wr_data_out), 32'h3C);
    check("wr_busy0",  32'(bus.busy_out), 32'd0);
    idle(2);

    // ALU with operands, then without
    send(8'hCC); send(8'h12); send(8'h34); send(8'h03);
    check("alu1_a", 32'(bus.alu_a_out), 32'h12);
    check("alu1_f", 32'(bus.alu_func_out), 32'h3);
    send(8'hDD); send(8'hF1);
    check("alu2_en", 32'(bus.alu_en_out), 32'd1);
    check("alu2_b",  32'(bus.alu_b_out), 32'h34);
    check("alu2_f",  32'(bus.alu_func_out), 32'h1);

    // Bad opcode
    send(8'h55);
    check("bad_op", 32'(bus.cmd_err_out), 32'd1);
    idle(1);

    // Timeout on an unfinished read, then a good read
    send(8'hBB);
    seen_tmo = 0;
    for (int i = 0; i < T + 3; i++) begin
      cycle(0, 0, 8'h00);
      if (bus.timeout_err_out) seen_tmo = 1;
    end
    check("tmo_seen", 32'(seen_tmo), 32'd1);
    check("tmo_addr", 32'(bus.reg_addr_out), 32'h5);
    send(8'hBB); send(8'h07);
    check("rd_addr7", 32'(bus.reg_addr_out), 32'h7);

    // Byte arriving on the expiry cycle is accepted
    send(8'hBB); idle(T - 1); send(8'h0A);
    check("rd_late", 32'(bus.reg_rd_en_out), 32'd1);

    // Reset mid-frame
    send(8'hAA); send(8'h02); cycle(1, 0, 8'h00);
    send(8'hBB); send(8'h09);
    check("rst_rd_addr", 32'(bus.reg_addr_out), 32'h9);

    // Back-to-back reads
    send(8'hBB); send(8'h01);
    check("b2b_addr1", 32'(bus.reg_addr_out), 32'h1);
    send(8'hBB); send(8'h02);
    check("b2b_addr2", 32'(bus.reg_addr_out), 32'h2);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 5) cycle(1, 0, 8'h00);
      else if (r < 10) idle(T + 2);
      else if (r < 500) begin
        if ($urandom_range(0, 9) < 5) send(opc[$urandom_range(0, 3)]);
        else send(8'($urandom));
      end else cycle(0, 0, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
